// File: rtl/baccarat_pkg.sv
// Shared types and helpers for the baccarat hand sequencer.
// Holds the state encoding, card constants and rank-to-value mapping.
package baccarat_pkg;

  typedef enum logic [3:0] {
    DEAL_P1   = 4'd0,
    DEAL_D1   = 4'd1,
    DEAL_P2   = 4'd2,
    DEAL_D2   = 4'd3,
    CHECK     = 4'd4,
    DEAL_P3   = 4'd5,
    DECIDE_D3 = 4'd6,
    DEAL_D3   = 4'd7,
    SCORE     = 4'd8,
    DONE      = 4'd9
  } state_t;

  localparam logic [3:0] RANK_NONE       = 4'd0;
  localparam logic [3:0] FACE_VALUE_MAX  = 4'd9;
  localparam logic [3:0] DEALER_DRAW_MAX = 4'd5;

  // Tens and face cards count zero; a missing card also counts zero.
  function automatic logic [3:0] rank_to_value(
    input logic [3:0] rank
  );
    if (rank == RANK_NONE || rank > FACE_VALUE_MAX)
      return 4'd0;
    return rank;
  endfunction

endpackage

// File: rtl/baccarat_sequencer_dealer_draw_rule.sv
// Dealer third-card rule once the player has drawn.
// Pure combinational lookup on dealer score and player third card.
module dealer_draw_rule
  import baccarat_pkg::*;
(
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       draw
);

  logic [3:0] v;

  assign v = rank_to_value(pcard3);

  always_comb begin
    draw = 1'b0;
    case (dscore)
      4'd0, 4'd1, 4'd2: draw = 1'b1;
      4'd3: draw = (v != 4'd8);
      4'd4: draw = (v >= 4'd2) && (v <= 4'd7);
      4'd5: draw = (v >= 4'd4) && (v <= 4'd7);
      4'd6: draw = (v >= 4'd6) && (v <= 4'd7);
      default: draw = 1'b0;
    endcase
  end

endmodule

// File: rtl/baccarat_sequencer.sv
// Moore controller stepping the card datapath through one hand.
// Emits one-hot card load strobes and latches the win lights.
module baccarat_sequencer
  import baccarat_pkg::*;
#(
  parameter logic [3:0] NAT_THRESH      = 4'd8,
  parameter logic [3:0] PLAYER_DRAW_MAX = 4'd5
) (
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       player_win_light,
  output logic       dealer_win_light
);

  state_t state, state_nxt;
  logic   d_draw;

  dealer_draw_rule u_rule (
    .dscore (dscore),
    .pcard3 (pcard3),
    .draw   (d_draw)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      DEAL_P1: state_nxt = DEAL_D1;
      DEAL_D1: state_nxt = DEAL_P2;
      DEAL_P2: state_nxt = DEAL_D2;
      DEAL_D2: state_nxt = CHECK;
      CHECK: begin
        if (pscore >= NAT_THRESH ||
            dscore >= NAT_THRESH)
          state_nxt = SCORE;
        else if (pscore <= PLAYER_DRAW_MAX)
          state_nxt = DEAL_P3;
        else if (dscore <= DEALER_DRAW_MAX)
          state_nxt = DEAL_D3;
        else
          state_nxt = SCORE;
      end
      DEAL_P3:   state_nxt = DECIDE_D3;
      DECIDE_D3: state_nxt = d_draw ? DEAL_D3 : SCORE;
      DEAL_D3:   state_nxt = SCORE;
      SCORE:     state_nxt = DONE;
      DONE:      state_nxt = DONE;
      default:   state_nxt = DEAL_P1;
    endcase
  end

  always_ff @(posedge slow_clock) begin
    if (!resetb) begin
      state            <= DEAL_P1;
      player_win_light <= 1'b0;
      dealer_win_light <= 1'b0;
    end else begin
      state <= state_nxt;
      // A tie lights both lamps.
      if (state == SCORE) begin
        player_win_light <= (pscore >= dscore);
        dealer_win_light <= (dscore >= pscore);
      end
    end
  end

  assign load_pcard1 = (state == DEAL_P1);
  assign load_dcard1 = (state == DEAL_D1);
  assign load_pcard2 = (state == DEAL_P2);
  assign load_dcard2 = (state == DEAL_D2);
  assign load_pcard3 = (state == DEAL_P3);
  assign load_dcard3 = (state == DEAL_D3);

endmodule

// File: doc/baccarat_sequencer.md
Name: baccarat_sequencer

Overview:
- Moore controller that sequences the baccarat card datapath through one hand per reset.
- Issues one-hot load strobes for player/dealer cards in deal order and applies the third-card rules to the datapath's scores and player third card.
- Drives the win lights.
- Clocked on the slow (game-step) clock; sits beside the datapath in the top level.

Parameters:
- NAT_THRESH, 8, minimum two-card score counting as a natural (hand ends, no third cards).
- PLAYER_DRAW_MAX, 5, player draws a third card when two-card score <= this.

Ports:
- slow_clock  input  1  game-step clock; all state changes on rising edge.
- resetb  input  1  synchronous active-low reset, sampled on the rising edge of slow_clock.
- pscore  input  4  player score 0-9 from datapath, valid the cycle after a load strobe.
- dscore  input  4  dealer score 0-9 from datapath, same timing as pscore.
- pcard3  input  4  player third card rank; 0 = no card, 1-13 = A..K.
- load_pcard1, load_pcard2, load_pcard3  output  1 each  player card load strobes.
- load_dcard1, load_dcard2, load_dcard3  output  1 each  dealer card load strobes.
- player_win_light  output  1  player wins (or tie).
- dealer_win_light  output  1  dealer wins (or tie).

Behaviour:
- Reset:
  - While resetb=0 at an edge: state <= DEAL_P1; both lights <= 0.
  - Load strobes are decoded from state, so load_pcard1=1 during reset and the first post-reset cycle.
  - The datapath is also in reset, so the strobe is harmless.
  - Reset mid-hand abandons the hand immediately; there is no cleanup state.
- States: DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2, CHECK, DEAL_P3, DECIDE_D3, DEAL_D3, SCORE, DONE.
- Strobes:
  - Exactly one strobe is high in each DEAL_* state (matching card); all strobes are low in every other state.
  - Never more than one strobe high in any cycle.
- Fixed sequence: DEAL_P1 -> DEAL_D1 -> DEAL_P2 -> DEAL_D2 -> CHECK, one cycle each.
- CHECK (four-card scores valid):
  - pscore>=NAT_THRESH or dscore>=NAT_THRESH -> SCORE (natural).
  - Else pscore<=PLAYER_DRAW_MAX -> DEAL_P3.
  - Else (player stands on 6/7): dscore<=5 -> DEAL_D3, else -> SCORE.
- DEAL_P3 -> DECIDE_D3 unconditionally.
- DECIDE_D3 (pcard3 now valid):
  - Third-card value v = rank if rank<=9, else 0 (10/J/Q/K).
  - Dealer draws when any of:
    - dscore<=2;
    - dscore==3 and v!=8;
    - dscore==4 and v in 2..7;
    - dscore==5 and v in 4..7;
    - dscore==6 and v in 6..7.
  - dscore==7 never draws.
  - Draw -> DEAL_D3, else -> SCORE.
  - pcard3==0 in DECIDE_D3 is a datapath fault: treat as v=0 (no assertion required).
- DEAL_D3 -> SCORE.
- SCORE: compare final scores and register the lights on the edge leaving SCORE.
  - pscore>dscore: player=1, dealer=0.
  - dscore>pscore: player=0, dealer=1.
  - Equal: both 1.
  - Next state DONE.
- DONE:
  - Self-loop; lights and strobes held (strobes 0) until resetb=0.
  - Score changes in DONE do not affect the lights.
- Latency, counting the first cycle after reset release as cycle 0:
  - Natural: lights visible in cycle 6.
  - Player stands, dealer draws: cycle 7.
  - Player draws, dealer stands: cycle 8.
  - Both draw: cycle 9.
- Inputs are compared as unsigned 4-bit values.
- Scores >9 never occur; if they do, apply the same comparisons with no saturation.

Decomposition:
- baccarat_pkg holds:
  - state enum (state_t, 4-bit encoding);
  - constants RANK_NONE=0 and FACE_VALUE_MAX=9;
  - a function rank_to_value.
- One combinational sub-module, dealer_draw_rule (inputs dscore, pcard3; output draw), used in DECIDE_D3 and tested standalone.
- The state register and output decode stay in baccarat_sequencer.

Test Plan:
- Natural: after D2, pscore=8, dscore=3 -> CHECK goes to SCORE, no load_pcard3/load_dcard3 ever high, player_win_light=1 and dealer_win_light=0 from cycle 6.
- Player stands, dealer draws: pscore=6, dscore=4 at CHECK -> load_dcard3 high in cycle 5, no load_pcard3. Dealer final 7 -> dealer_win_light=1, player_win_light=0 in cycle 7.
- Player draws, dealer stands: pscore=3, dscore=6, pcard3=13 (v=0) -> load_pcard3 in cycle 5, DECIDE_D3 chooses SCORE. Final pscore=3 vs 6 -> dealer light only, cycle 8.
- Rule sweep on dealer_draw_rule: dscore 0..7 x pcard3 1..13 -> draw matches the rule table exactly. Spot checks:
  - (3,8)=0
  - (3,12)=1
  - (6,7)=1
  - (5,3)=0
  - (7,x)=0
- Tie after both draw: pscore=2, dscore=2, pcard3=5 -> both third cards loaded (cycles 5, 7). Final scores both 4 -> both lights 1 in cycle 9 and held through 5 extra cycles.
- Reset mid-hand: resetb=0 during DEAL_P3 -> next state DEAL_P1 with lights 0. After release, the full strobe sequence restarts from load_pcard1 in cycle 0.
